heap_priority_queue: RTL and testbench

HEAP_PRIORITY_QUEUE -- requirements
Module: heap_priority_queue

---
 rtl/heap_priority_queue.sv | 226 ++++++++++++++++++++++
 tb/tb_heap_priority_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_priority_queue.sv
// Binary-heap priority queue (max- or min-heap) with one compare-swap step per cycle.
// Optional peek command (op 11) is built only when HEAP_PEEK_EN is defined.
module heap_priority_queue #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int MIN_HEAP = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_v,
    output logic                     in_ready,
    input  logic [1:0]               op,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_v,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [AW+1:0] WIDE_TWO = (AW+2)'(2);

    typedef enum logic [1:0] {
        IDLE,
        SIFT_UP,
        SIFT_DOWN
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_count;
    logic [AW-1:0]       r_idx;
    logic                r_outV;
    logic                r_outErr;
    logic [DATA_W-1:0]   r_outData;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_accept;
    logic                w_full;
    logic                w_empty;
    logic [AW-1:0]       w_lastIdx;
    logic [AW-1:0]       w_parentIdx;
    logic [AW+1:0]       w_leftIdx;
    logic [AW+1:0]       w_rightIdx;
    logic [AW+1:0]       w_countWide;
    logic                w_leftValid;
    logic                w_rightValid;
    logic [DATA_W-1:0]   w_curVal;
    logic [DATA_W-1:0]   w_parentVal;
    logic [DATA_W-1:0]   w_leftVal;
    logic [DATA_W-1:0]   w_rightVal;
    logic                w_pickRight;
    logic [AW-1:0]       w_childIdx;
    logic [DATA_W-1:0]   w_childVal;
    logic                w_upSwap;
    logic                w_downSwap;
    logic                w_we0;
    logic [AW-1:0]       w_wa0;
    logic [DATA_W-1:0]   w_wd0;
    logic                w_we1;
    logic [AW-1:0]       w_wa1;
    logic [DATA_W-1:0]   w_wd1;

    // "Beats" is strict, so equal keys never move.
    function automatic logic beats(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (MIN_HEAP != 0) return a < b;
        else               return a > b;
    endfunction

    assign w_accept     = in_v && (r_state == IDLE);
    assign w_full       = (r_count == FULL_CNT);
    assign w_empty      = (r_count == '0);
    assign w_lastIdx    = r_count[AW-1:0] - IDX_ONE;
    assign w_parentIdx  = (r_idx - IDX_ONE) >> 1;
    assign w_leftIdx    = {1'b0, r_idx, 1'b1};
    assign w_rightIdx   = {1'b0, r_idx, 1'b0} + WIDE_TWO;
    assign w_countWide  = {1'b0, r_count};
    assign w_leftValid  = (w_leftIdx < w_countWide);
    assign w_rightValid = (w_rightIdx < w_countWide);
    assign w_curVal     = r_mem[r_idx];
    assign w_parentVal  = r_mem[w_parentIdx];
    assign w_leftVal    = r_mem[w_leftIdx[AW-1:0]];
    assign w_rightVal   = r_mem[w_rightIdx[AW-1:0]];
    assign w_pickRight  = w_rightValid && beats(w_rightVal, w_leftVal);
    assign w_childIdx   = w_pickRight ? w_rightIdx[AW-1:0] : w_leftIdx[AW-1:0];
    assign w_childVal   = w_pickRight ? w_rightVal : w_leftVal;
    assign w_upSwap     = (r_idx != '0) && beats(w_curVal, w_parentVal);
    assign w_downSwap   = w_leftValid && beats(w_childVal, w_curVal);

    // Two write ports: a swap rewrites both ends of one parent/child edge.
    always_comb begin
        w_we0 = 1'b0;
        w_wa0 = '0;
        w_wd0 = '0;
        w_we1 = 1'b0;
        w_wa1 = '0;
        w_wd1 = '0;
        case (r_state)
            IDLE: begin
                if (w_accept && op == 2'b01 && !w_full) begin
                    w_we0 = 1'b1;
                    w_wa0 = r_count[AW-1:0];
                    w_wd0 = in_data;
                end else if (w_accept && op == 2'b10 && !w_empty) begin
                    w_we0 = 1'b1;
                    w_wa0 = '0;
                    w_wd0 = r_mem[w_lastIdx];
                end
            end
            SIFT_UP: begin
                if (w_upSwap) begin
                    w_we0 = 1'b1;
                    w_wa0 = r_idx;
                    w_wd0 = w_parentVal;
                    w_we1 = 1'b1;
                    w_wa1 = w_parentIdx;
                    w_wd1 = w_curVal;
                end
            end
            SIFT_DOWN: begin
                if (w_downSwap) begin
                    w_we0 = 1'b1;
                    w_wa0 = r_idx;
                    w_wd0 = w_childVal;
                    w_we1 = 1'b1;
                    w_wa1 = w_childIdx;
                    w_wd1 = w_curVal;
                end
            end
            default: ;
        endcase
    end

    // Storage is deliberately not reset; the count alone defines what is live.
    always_ff @(posedge clk) begin
        if (w_we0) r_mem[w_wa0] <= w_wd0;
        if (w_we1) r_mem[w_wa1] <= w_wd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_idx     <= '0;
            r_outV    <= 1'b0;
            r_outErr  <= 1'b0;
            r_outData <= '0;
        end else begin
            r_outV <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (op)
                            2'b01: begin
                                if (w_full) begin
                                    r_outV   <= 1'b1;
                                    r_outErr <= 1'b1;
                                end else begin
                                    r_count <= r_count + CNT_ONE;
                                    r_idx   <= r_count[AW-1:0];
                                    r_state <= SIFT_UP;
                                end
                            end
                            2'b10: begin
                                if (w_empty) begin
                                    r_outV   <= 1'b1;
                                    r_outErr <= 1'b1;
                                end else begin
                                    r_outData <= r_mem[0];
                                    r_outV    <= 1'b1;
                                    r_outErr  <= 1'b0;
                                    r_count   <= r_count - CNT_ONE;
                                    r_idx     <= '0;
                                    r_state   <= (r_count == CNT_ONE) ? IDLE : SIFT_DOWN;
                                end
                            end
`ifdef HEAP_PEEK_EN
                            2'b11: begin
                                r_outV <= 1'b1;
                                if (w_empty) begin
                                    r_outErr <= 1'b1;
                                end else begin
                                    r_outData <= r_mem[0];
                                    r_outErr  <= 1'b0;
                                end
                            end
`endif
                            default: begin
                                r_outV   <= 1'b1;
                                r_outErr <= 1'b1;
                            end
                        endcase
                    end
                end
                SIFT_UP: begin
                    // Finishing on the swap into the root keeps the worst case at log2(DEPTH) cycles.
                    if (w_upSwap) begin
                        r_idx <= w_parentIdx;
                        if (w_parentIdx == '0) r_state <= IDLE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SIFT_DOWN: begin
                    if (w_downSwap) r_idx <= w_childIdx;
                    else            r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready = (r_state == IDLE);
    assign out_v    = r_outV;
    assign out_err  = r_outErr;
    assign out_data = r_outData;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;

endmodule

// File: tb/tb_heap_priority_queue.sv
// Bench for heap_priority_queue: three instances (max DEPTH=8, min DEPTH=8, max DEPTH=4)
// checked against an unordered-array reference model; peek expectations follow HEAP_PEEK_EN.
module tb_heap_priority_queue;

    localparam int DW = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic [2:0]        inV;
    logic [1:0]        opCode [3];
    logic [DW-1:0]     inData [3];
    logic [2:0]        inReady;
    logic [2:0]        outV;
    logic [2:0]        outErr;
    logic [2:0]        full;
    logic [2:0]        empty;
    logic [DW-1:0]     outData [3];
    logic [3:0]        countA;
    logic [3:0]        countB;
    logic [2:0]        countC;

    int                checks = 0;
    int                errors = 0;
    logic [DW-1:0]     mdlData [3][8];
    int                mdlSize [3];
    logic [DW-1:0]     lastOut [3];
    int                depthOf [3] = '{8, 8, 4};
    int                isMin   [3] = '{0, 1, 0};
    int                log2Of  [3] = '{3, 3, 2};

    always #5 clock = ~clock;

    heap_priority_queue #(.DATA_W(DW), .DEPTH(8), .MIN_HEAP(0)) uMaxHeap (
        .clk(clock), .reset(reset), .in_v(inV[0]), .in_ready(inReady[0]), .op(opCode[0]),
        .in_data(inData[0]), .out_v(outV[0]), .out_data(outData[0]), .out_err(outErr[0]),
        .count(countA), .full(full[0]), .empty(empty[0]));

    heap_priority_queue #(.DATA_W(DW), .DEPTH(8), .MIN_HEAP(1)) uMinHeap (
        .clk(clock), .reset(reset), .in_v(inV[1]), .in_ready(inReady[1]), .op(opCode[1]),
        .in_data(inData[1]), .out_v(outV[1]), .out_data(outData[1]), .out_err(outErr[1]),
        .count(countB), .full(full[1]), .empty(empty[1]));

    heap_priority_queue #(.DATA_W(DW), .DEPTH(4), .MIN_HEAP(0)) uSmallHeap (
        .clk(clock), .reset(reset), .in_v(inV[2]), .in_ready(inReady[2]), .op(opCode[2]),
        .in_data(inData[2]), .out_v(outV[2]), .out_data(outData[2]), .out_err(outErr[2]),
        .count(countC), .full(full[2]), .empty(empty[2]));

    function automatic logic [31:0] getCount(input int k);
        case (k)
            0:       return {28'd0, countA};
            1:       return {28'd0, countB};
            default: return {29'd0, countC};
        endcase
    endfunction

    // Reference model: unordered bag, the winner is found by a linear scan.
    function automatic int modelTopIdx(input int k);
        int best = 0;
        for (int i = 1; i < mdlSize[k]; i++) begin
            if (isMin[k] != 0 ? (mdlData[k][i] < mdlData[k][best]) : (mdlData[k][i] > mdlData[k][best]))
                best = i;
        end
        return best;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input int k, input string tag);
        checkOutput({tag, "_count"}, getCount(k), 32'd0);
        checkOutput({tag, "_ready"}, 32'(inReady[k]), 32'd1);
        checkOutput({tag, "_empty"}, 32'(empty[k]), 32'd1);
        checkOutput({tag, "_full"}, 32'(full[k]), 32'd0);
        checkOutput({tag, "_outv"}, 32'(outV[k]), 32'd0);
        checkOutput({tag, "_outerr"}, 32'(outErr[k]), 32'd0);
        checkOutput({tag, "_outdata"}, 32'(outData[k]), 32'd0);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mdlSize[k] = 0;
            lastOut[k] = '0;
        end
    endtask

    // Called on a falling edge; returns on a falling edge unless keepBusy is set.
    task automatic applyStimulus(input int k, input logic [1:0] code, input logic [DW-1:0] data,
                                 input string tag, input bit keepBusy = 1'b0);
        int            waitCycles;
        int            busy;
        int            top;
        bit            expErr;
        bit            expOutV;
        logic [DW-1:0] expData;
        waitCycles = 0;
        while (inReady[k] !== 1'b1 && waitCycles < 64) begin
            @(negedge clock);
            waitCycles++;
        end
        checkOutput({tag, "_ready"}, 32'(inReady[k]), 32'd1);
        expErr  = 1'b0;
        expOutV = 1'b0;
        expData = lastOut[k];
        case (code)
            2'b01: begin
                if (mdlSize[k] == depthOf[k]) expErr = 1'b1;
                else begin
                    mdlData[k][mdlSize[k]] = data;
                    mdlSize[k]++;
                end
            end
            2'b10: begin
                if (mdlSize[k] == 0) expErr = 1'b1;
                else begin
                    top = modelTopIdx(k);
                    expData = mdlData[k][top];
                    mdlData[k][top] = mdlData[k][mdlSize[k]-1];
                    mdlSize[k]--;
                    expOutV = 1'b1;
                end
            end
            2'b11: begin
`ifdef HEAP_PEEK_EN
                if (mdlSize[k] == 0) expErr = 1'b1;
                else begin
                    expData = mdlData[k][modelTopIdx(k)];
                    expOutV = 1'b1;
                end
`else
                expErr = 1'b1;
`endif
            end
            default: expErr = 1'b1;
        endcase
        if (expErr) expOutV = 1'b1;
        lastOut[k] = expData;
        inV[k] = 1'b1;
        opCode[k] = code;
        inData[k] = data;
        @(posedge clock);
        #1;
        inV[k] = 1'b0;
        opCode[k] = 2'b00;
        checkOutput({tag, "_outv"}, 32'(outV[k]), 32'(expOutV));
        if (expOutV) begin
            checkOutput({tag, "_outerr"}, 32'(outErr[k]), 32'(expErr));
            checkOutput({tag, "_outdata"}, 32'(outData[k]), 32'(expData));
        end
        checkOutput({tag, "_count"}, getCount(k), 32'(mdlSize[k]));
        checkOutput({tag, "_full"}, 32'(full[k]), 32'(mdlSize[k] == depthOf[k]));
        checkOutput({tag, "_empty"}, 32'(empty[k]), 32'(mdlSize[k] == 0));
        if (!keepBusy) begin
            busy = 0;
            while (inReady[k] !== 1'b1 && busy < 64) begin
                @(posedge clock);
                #1;
                busy++;
            end
            checks++;
            assert (busy <= log2Of[k]) else begin
                errors++;
                $error("[TB] FAIL %s_busy observed=%0d expected<=%0d", tag, busy, log2Of[k]);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        reset = 1'b1;
        inV = '0;
        for (int k = 0; k < 3; k++) begin
            opCode[k] = 2'b00;
            inData[k] = '0;
        end
        repeat (3) @(negedge clock);
        pulseReset();
        for (int k = 0; k < 3; k++) checkResetState(k, "reset");

        // Max-heap ordering
        applyStimulus(0, 2'b01, 16'd5, "max_push");
        applyStimulus(0, 2'b01, 16'd3, "max_push");
        applyStimulus(0, 2'b01, 16'd9, "max_push");
        applyStimulus(0, 2'b01, 16'd1, "max_push");
        applyStimulus(0, 2'b01, 16'd7, "max_push");
        for (int i = 0; i < 5; i++) applyStimulus(0, 2'b10, '0, "max_pop");
        checkOutput("max_final_empty", 32'(empty[0]), 32'd1);
        checkOutput("max_last_pop", 32'(outData[0]), 32'd1);

        // Min-heap ordering
        applyStimulus(1, 2'b01, 16'd40, "min_push");
        applyStimulus(1, 2'b01, 16'd10, "min_push");
        applyStimulus(1, 2'b01, 16'd30, "min_push");
        applyStimulus(1, 2'b01, 16'd20, "min_push");
        for (int i = 0; i < 4; i++) applyStimulus(1, 2'b10, '0, "min_pop");
        checkOutput("min_last_pop", 32'(outData[1]), 32'd40);

        // Full boundary on the 4-entry heap
        for (int i = 1; i <= 4; i++) applyStimulus(2, 2'b01, 16'(i), "small_fill");
        applyStimulus(2, 2'b01, 16'd5, "small_overflow");
        applyStimulus(2, 2'b10, '0, "small_pop");
        checkOutput("small_pop_value", 32'(outData[2]), 32'd4);
        for (int i = 0; i < 3; i++) applyStimulus(2, 2'b10, '0, "small_drain");

        // Empty pop, duplicates, illegal op, peek
        applyStimulus(0, 2'b10, '0, "empty_pop");
        for (int i = 0; i < 3; i++) applyStimulus(0, 2'b01, 16'd7, "dup_push");
        for (int i = 0; i < 3; i++) applyStimulus(0, 2'b10, '0, "dup_pop");
        applyStimulus(0, 2'b00, '0, "illegal_op");
        applyStimulus(0, 2'b01, 16'd2, "peek_push");
        applyStimulus(0, 2'b01, 16'd9, "peek_push");
        applyStimulus(0, 2'b11, '0, "peek");
        applyStimulus(0, 2'b10, '0, "peek_pop");
        applyStimulus(0, 2'b10, '0, "peek_pop");
        applyStimulus(0, 2'b11, '0, "peek_empty");

        // Randomized traffic with small keys to force ties and full/empty hits
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 120; n++) begin
                r = int'($urandom_range(0, 99));
                if (r < 55)      applyStimulus(k, 2'b01, DW'($urandom_range(0, 31)), "rand_push");
                else if (r < 95) applyStimulus(k, 2'b10, '0, "rand_pop");
                else if (r < 98) applyStimulus(k, 2'b11, '0, "rand_peek");
                else             applyStimulus(k, 2'b00, '0, "rand_illegal");
            end
        end

        // Reset while a sift-down is in flight
        pulseReset();
        applyStimulus(0, 2'b01, 16'd8, "rst_push");
        applyStimulus(0, 2'b01, 16'd6, "rst_push");
        applyStimulus(0, 2'b01, 16'd4, "rst_push");
        applyStimulus(0, 2'b10, '0, "rst_pop", 1'b1);
        checkOutput("rst_midsift_busy", 32'(inReady[0]), 32'd0);
        pulseReset();
        for (int k = 0; k < 3; k++) checkResetState(k, "rst_after");
        applyStimulus(0, 2'b10, '0, "rst_next_pop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
